tft_pattern_seq: RTL and testbench
==================================

# tft_pattern_seq

Frame-synchronous pattern scheduler and backlight sequencer for the TFT colorbar path. It runs in the 9 MHz TFT pixel clock domain beside the timing controller and picture generator, and counts frames from `vsync`. It steps the picture generator through `PAT_NUM` test patterns, fading the backlight out and back in around every pattern change. Patterns advance on a dwell timeout or on a manual request, and the block replaces a static `tft_bl` tie-off.

## Interface
- `PAT_NUM`, 4: number of patterns; `pat_sel` cycles 0..PAT_NUM-1.
- `DWELL_FRAMES`, 120: frames held at full brightness before auto-advance (≥1).
- `PWM_W`, 4: PWM counter width; brightness range is 0..2^PWM_W.

Ports:
- `tft_clk` in 1: pixel clock, the only clock.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `vsync` in 1: frame sync from the timing controller, active-high, synchronous to `tft_clk`.
- `enable` in 1: level; 1 means run the sequence, 0 means fade out and park.
- `key_next` in 1: one-cycle pulse, already debounced; requests early advance.
- `pat_sel` out $clog2(PAT_NUM): pattern index to the picture generator.
- `pat_chg` out 1: one-cycle pulse when `pat_sel` changes.
- `tft_bl` out 1: backlight PWM.
- `busy` out 1: high in every state except IDLE.

## Operation
- `frame_tick`: a registered rising-edge detect of `vsync`. It is high for exactly one cycle, the cycle after `vsync` goes 0→1.
- `bright` register: width PWM_W+1, range 0..2^PWM_W.
- `pwm_cnt`: free-running, PWM_W bits, wraps.
- `tft_bl` is registered as (`pwm_cnt` < `bright`). As a result, `bright`=0 gives constant low and `bright`=2^PWM_W gives constant high.
- FSM states: IDLE, FADE_IN, DWELL, FADE_OUT, SWITCH.
- IDLE:
  - `bright`=0.
  - `enable`=1 → FADE_IN.
- FADE_IN:
  - Each `frame_tick` increments `bright`.
  - `bright` reaches 2^PWM_W → DWELL, clearing `frame_cnt`.
- DWELL:
  - Each `frame_tick` increments `frame_cnt`.
  - `frame_tick` with `frame_cnt`==DWELL_FRAMES-1 → FADE_OUT (advance).
  - `key_next` → FADE_OUT (advance).
  - Both in the same cycle → a single FADE_OUT entry.
- FADE_OUT:
  - Each `frame_tick` decrements `bright`.
  - `bright`==0 → SWITCH if advancing, or IDLE if stopping.
- SWITCH:
  - Lasts one cycle, with `pat_chg`=1.
  - `pat_sel` ← (`pat_sel`==PAT_NUM-1) ? 0 : `pat_sel`+1, taking effect at the exiting edge.
  - Then → FADE_IN.
- Stop (`enable`=0):
  - Seen in FADE_IN or DWELL: set the `stop` flag and go to FADE_OUT, starting from the current `bright`.
  - Seen in FADE_OUT: set `stop`.
  - Seen in SWITCH: ignored; the switch completes, and `stop` is sampled again in FADE_IN.
  - `stop` clears on entry to IDLE. `pat_sel` is held through a stop.
- `key_next` outside DWELL is ignored, not queued.
- Saturation: `bright` never underflows or overflows, and `frame_cnt` never exceeds DWELL_FRAMES-1.

## Timing
- Reset values:
  - state IDLE, `pat_sel`=0, `bright`=0, `pwm_cnt`=0, `frame_cnt`=0.
  - `tft_bl`=0, `pat_chg`=0, `busy`=0, `stop`=0.
- Reset asserted mid-sequence returns everything to the reset values immediately (asynchronously), including `tft_bl`=0.
- `enable` rise in IDLE → FADE_IN on the next edge, and `busy`=1 one cycle later.
- Fade length: exactly 2^PWM_W `frame_tick`s in each direction from the extremes.
- `pat_chg` is high during the SWITCH cycle. The new `pat_sel` is visible the following cycle, while `bright`=0, so a pattern change is never visible on a lit panel.
- `tft_bl` lags the `bright`/`pwm_cnt` compare by one cycle.
- Full auto cycle per pattern: 2^PWM_W + DWELL_FRAMES + 2^PWM_W frames, plus 1 clock.

## Structure
- Package `tft_pkg` holds:
  - the state enum `seq_state_t`;
  - the default `PAT_NUM`, `DWELL_FRAMES` and `PWM_W` constants, shared with the picture generator, which decodes `pat_sel`.
- Sub-module `tft_bl_pwm` contains:
  - `pwm_cnt` and the registered compare producing `tft_bl`;
  - inputs: `tft_clk`, `sys_rst_n`, `bright`.
- The top level holds the FSM, the vsync edge detect, `frame_cnt` and `pat_sel`.

## Test plan
All scenarios use `PAT_NUM`=3, `DWELL_FRAMES`=3, `PWM_W`=2 and a short synthetic `vsync` frame.
- Reset with `enable`=1 → after 4 frame_ticks `bright`=4 and `tft_bl` constantly 1. After 3 more → FADE_OUT. After 4 more → `pat_chg` pulses once and `pat_sel`=1.
- Run to `pat_sel`=2 and let it advance → `pat_sel` wraps to 0, and `pat_chg` is exactly one cycle wide.
- `key_next` in DWELL on its first frame → immediate FADE_OUT. `key_next` during FADE_IN → no effect, and DWELL still lasts 3 frames.
- `enable`→0 in FADE_IN at `bright`=2 → 2 frame_ticks to `bright`=0, then IDLE with `pat_sel` unchanged, no `pat_chg` and `busy`=0.
- `bright`=2 → `tft_bl` duty is 2/4, checked over 8 clocks. `bright`=0 → `tft_bl` constantly 0.
- Assert `sys_rst_n`=0 during DWELL → `tft_bl`, `busy` and `pat_sel` are 0 without waiting for a clock edge. Release → IDLE.

Source files
------------

// File: rtl/tft_pattern_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tft_pkg
//  Description : Shared types and default sizing for the TFT colorbar path.
//                The picture generator decodes pat_sel using C_PAT_NUM, so
//                both blocks take their defaults from here.
//  Contents    : seq_state_t   - pattern sequencer state encoding
//                C_PAT_NUM     - number of test patterns
//                C_DWELL_FRAMES- frames held at full brightness
//                C_PWM_W       - backlight PWM counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package tft_pkg;

   localparam int C_PAT_NUM      = 4;
   localparam int C_DWELL_FRAMES = 120;
   localparam int C_PWM_W        = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FADE_IN  = 3'd1,
      ST_DWELL    = 3'd2,
      ST_FADE_OUT = 3'd3,
      ST_SWITCH   = 3'd4
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/tft_bl_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tft_bl_pwm
//  Description : Backlight PWM. Free-running counter compared against the
//                brightness level; the compare result is registered.
//  Ports       : tft_clk   in  - pixel clock
//                sys_rst_n in  - asynchronous active-low reset
//                bright    in  - brightness 0..2^PWM_W
//                tft_bl    out - registered PWM output
//  Revision    : 1.0 - initial release
// ============================================================================
module tft_bl_pwm #(
   parameter int PWM_W = 4
) (
   input  logic             tft_clk,
   input  logic             sys_rst_n,
   input  logic [PWM_W:0]   bright,
   output logic             tft_bl
);

   logic [PWM_W-1:0] r_pwm_cnt;
   logic             r_bl;

   // bright is one bit wider than the counter, so bright==2^PWM_W is
   // greater than every counter value and the output stays high.
   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pwm_cnt <= '0;
         r_bl      <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
         r_bl      <= ({1'b0, r_pwm_cnt} < bright);
      end
   end

   assign tft_bl = r_bl;

endmodule
`default_nettype wire

// File: rtl/tft_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tft_pattern_seq
//  Description : Frame-synchronous pattern scheduler and backlight sequencer.
//                Fades the backlight in, dwells, fades out, then steps the
//                pattern index while the panel is dark.
//  Ports       : tft_clk   in  - pixel clock
//                sys_rst_n in  - asynchronous active-low reset
//                vsync     in  - frame sync, active high
//                enable    in  - 1 run sequence, 0 fade out and park
//                key_next  in  - one-cycle early-advance request
//                pat_sel   out - pattern index
//                pat_chg   out - one-cycle pulse while the index steps
//                tft_bl    out - backlight PWM
//                busy      out - high outside IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module tft_pattern_seq
   import tft_pkg::*;
#(
   parameter int PAT_NUM      = C_PAT_NUM,
   parameter int DWELL_FRAMES = C_DWELL_FRAMES,
   parameter int PWM_W        = C_PWM_W
) (
   input  logic                       tft_clk,
   input  logic                       sys_rst_n,
   input  logic                       vsync,
   input  logic                       enable,
   input  logic                       key_next,
   output logic [$clog2(PAT_NUM)-1:0] pat_sel,
   output logic                       pat_chg,
   output logic                       tft_bl,
   output logic                       busy
);

   localparam int             SEL_W        = $clog2(PAT_NUM);
   localparam int             CNT_W        = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam logic [PWM_W:0] C_BRIGHT_MAX = {1'b1, {PWM_W{1'b0}}};
   localparam logic [PWM_W:0] C_BRIGHT_ONE = {{PWM_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] C_LAST_FRAME = CNT_W'(DWELL_FRAMES - 1);
   localparam logic [SEL_W-1:0] C_LAST_PAT   = SEL_W'(PAT_NUM - 1);

   seq_state_t       r_state, w_state_nxt;
   logic             r_vsync_d;
   logic             r_frame_tick;
   logic [PWM_W:0]   r_bright, w_bright_nxt;
   logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
   logic [SEL_W-1:0] r_pat_sel, w_pat_sel_nxt;
   logic             r_stop, w_stop_nxt;

   // Registered rising-edge detect: one tick per frame, one cycle after vsync rises.
   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_vsync_d    <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_vsync_d    <= vsync;
         r_frame_tick <= vsync & ~r_vsync_d;
      end
   end

   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_bright    <= '0;
         r_frame_cnt <= '0;
         r_pat_sel   <= '0;
         r_stop      <= 1'b0;
      end else begin
         r_bright    <= w_bright_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_pat_sel   <= w_pat_sel_nxt;
         r_stop      <= w_stop_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_bright_nxt    = r_bright;
      w_frame_cnt_nxt = r_frame_cnt;
      w_pat_sel_nxt   = r_pat_sel;
      w_stop_nxt      = r_stop;

      case (r_state)
         ST_IDLE: begin
            w_bright_nxt = '0;
            w_stop_nxt   = 1'b0;
            if (enable) begin
               w_state_nxt = ST_FADE_IN;
            end
         end

         ST_FADE_IN: begin
            // A stop fades out from the current level, so it wins over the increment.
            if (!enable) begin
               w_stop_nxt  = 1'b1;
               w_state_nxt = ST_FADE_OUT;
            end else if (r_bright == C_BRIGHT_MAX) begin
               w_frame_cnt_nxt = '0;
               w_state_nxt     = ST_DWELL;
            end else if (r_frame_tick) begin
               w_bright_nxt = r_bright + C_BRIGHT_ONE;
            end
         end

         ST_DWELL: begin
            if (!enable) begin
               w_stop_nxt  = 1'b1;
               w_state_nxt = ST_FADE_OUT;
            end else if (key_next || (r_frame_tick && r_frame_cnt == C_LAST_FRAME)) begin
               w_state_nxt = ST_FADE_OUT;
            end else if (r_frame_tick) begin
               w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
            end
         end

         ST_FADE_OUT: begin
            if (!enable) begin
               w_stop_nxt = 1'b1;
            end
            if (r_bright == '0) begin
               // A stop seen in this very cycle still parks instead of switching.
               if (r_stop || !enable) begin
                  w_stop_nxt  = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_SWITCH;
               end
            end else if (r_frame_tick) begin
               w_bright_nxt = r_bright - C_BRIGHT_ONE;
            end
         end

         ST_SWITCH: begin
            // enable is deliberately not looked at here; FADE_IN re-samples it.
            w_pat_sel_nxt = (r_pat_sel == C_LAST_PAT) ? '0 : r_pat_sel + SEL_W'(1);
            w_state_nxt   = ST_FADE_IN;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   tft_bl_pwm #(
      .PWM_W     (PWM_W)
   ) u_bl_pwm (
      .tft_clk   (tft_clk),
      .sys_rst_n (sys_rst_n),
      .bright    (r_bright),
      .tft_bl    (tft_bl)
   );

   assign pat_sel = r_pat_sel;
   assign pat_chg = (r_state == ST_SWITCH);
   assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tft_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tft_pattern_seq
//  Description : Self-checking bench for tft_pattern_seq with PAT_NUM=3,
//                DWELL_FRAMES=3, PWM_W=2 and an 8-clock synthetic frame.
//                Expected pattern indices are queued when an advance is
//                provoked and compared when the DUT pulses pat_chg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tft_pattern_seq;
   import tft_pkg::*;

   localparam int PAT_NUM      = 3;
   localparam int DWELL_FRAMES = 3;
   localparam int PWM_W        = 2;
   localparam int FRAME_LEN    = 8;

   logic       tft_clk = 1'b0;
   logic       sys_rst_n;
   logic       vsync;
   logic       enable;
   logic       key_next;
   logic [1:0] pat_sel;
   logic       pat_chg;
   logic       tft_bl;
   logic       busy;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_chg = 0;
   int unsigned q_pat[$];
   logic        chg_seen = 1'b0;
   int          ones;

   always #5 tft_clk = ~tft_clk;

   tft_pattern_seq #(
      .PAT_NUM      (PAT_NUM),
      .DWELL_FRAMES (DWELL_FRAMES),
      .PWM_W        (PWM_W)
   ) dut (
      .tft_clk   (tft_clk),
      .sys_rst_n (sys_rst_n),
      .vsync     (vsync),
      .enable    (enable),
      .key_next  (key_next),
      .pat_sel   (pat_sel),
      .pat_chg   (pat_chg),
      .tft_bl    (tft_bl),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge tft_clk);
         #1;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         vsync = 1'b1;
         cyc(1);
         vsync = 1'b0;
         cyc(FRAME_LEN - 1);
      end
   endtask

   task automatic bl_ones(output int cnt);
      cnt = 0;
      repeat (8) begin
         cyc(1);
         cnt += int'(tft_bl);
      end
   endtask

   // Scoreboard side: the cycle after every pat_chg, the index must match
   // the next queued expectation and the pulse must already be gone.
   always @(negedge tft_clk) begin
      if (!sys_rst_n) begin
         chg_seen = 1'b0;
      end else begin
         if (chg_seen) begin
            check("chg_width", 32'(pat_chg), 32'd0);
            check("chg_expected", 32'(q_pat.size() != 0), 32'd1);
            if (q_pat.size() != 0) begin
               check("pat_sel_new", 32'(pat_sel), q_pat.pop_front());
            end
         end
         if (pat_chg) n_chg++;
         chg_seen = pat_chg;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst_n = 1'b1;
      vsync     = 1'b0;
      enable    = 1'b1;
      key_next  = 1'b0;
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("rst_pat_sel", 32'(pat_sel), 32'd0);
      check("rst_pat_chg", 32'(pat_chg), 32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_tft_bl",  32'(tft_bl),  32'd0);
      cyc(2);
      check("rst_bright",  32'(dut.r_bright), 32'd0);
      sys_rst_n = 1'b1;

      // Pattern 0: auto advance after fade-in and 3 dwell frames.
      cyc(2);
      check("busy_run", 32'(busy), 32'd1);
      frames(4);
      check("a_bright_full", 32'(dut.r_bright), 32'd4);
      bl_ones(ones);
      check("a_bl_full", 32'(ones), 32'd8);
      frames(2);
      check("a_dwell_hold", 32'(dut.r_state), 32'(ST_DWELL));
      frames(1);
      check("a_fade_out", 32'(dut.r_state), 32'(ST_FADE_OUT));
      q_pat.push_back(1);
      frames(4);
      check("a_pat_sel", 32'(pat_sel), 32'd1);
      check("a_chg_cnt", 32'(n_chg), 32'd1);

      // Pattern 1: key_next during FADE_IN is dropped; dwell still 3 frames.
      key_next = 1'b1;
      cyc(1);
      key_next = 1'b0;
      frames(4);
      check("b_dwell", 32'(dut.r_state), 32'(ST_DWELL));
      frames(2);
      check("b_dwell_hold", 32'(dut.r_state), 32'(ST_DWELL));
      frames(1);
      check("b_fade_out", 32'(dut.r_state), 32'(ST_FADE_OUT));
      q_pat.push_back(2);
      frames(4);
      check("b_pat_sel", 32'(pat_sel), 32'd2);

      // Pattern 2: auto advance wraps back to 0.
      frames(7);
      q_pat.push_back(0);
      frames(4);
      check("c_pat_wrap", 32'(pat_sel), 32'd0);

      // Pattern 0: key_next on the first dwell frame advances at once.
      frames(4);
      check("d_dwell", 32'(dut.r_state), 32'(ST_DWELL));
      key_next = 1'b1;
      cyc(1);
      key_next = 1'b0;
      check("d_key_fade_out", 32'(dut.r_state), 32'(ST_FADE_OUT));
      check("d_key_bright", 32'(dut.r_bright), 32'd4);
      q_pat.push_back(1);
      frames(4);
      check("d_pat_sel", 32'(pat_sel), 32'd1);

      // Pattern 1: half brightness duty, then stop mid fade-in.
      frames(2);
      check("e_bright_half", 32'(dut.r_bright), 32'd2);
      bl_ones(ones);
      check("e_bl_duty", 32'(ones), 32'd4);
      enable = 1'b0;
      cyc(1);
      check("e_stop_fade", 32'(dut.r_state), 32'(ST_FADE_OUT));
      frames(1);
      check("e_stop_busy", 32'(busy), 32'd1);
      frames(1);
      check("e_idle", 32'(dut.r_state), 32'(ST_IDLE));
      check("e_idle_busy", 32'(busy), 32'd0);
      check("e_pat_held", 32'(pat_sel), 32'd1);
      bl_ones(ones);
      check("e_bl_dark", 32'(ones), 32'd0);
      check("e_chg_cnt", 32'(n_chg), 32'd4);

      // Restart, then async reset in DWELL.
      enable = 1'b1;
      frames(5);
      check("f_dwell", 32'(dut.r_state), 32'(ST_DWELL));
      check("f_bl_lit", 32'(tft_bl), 32'd1);
      @(posedge tft_clk);
      #2;
      enable    = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      check("f_rst_bl",      32'(tft_bl),  32'd0);
      check("f_rst_busy",    32'(busy),    32'd0);
      check("f_rst_pat_sel", 32'(pat_sel), 32'd0);
      cyc(1);
      sys_rst_n = 1'b1;
      cyc(2);
      check("f_rel_idle", 32'(dut.r_state), 32'(ST_IDLE));
      check("f_rel_busy", 32'(busy), 32'd0);
      check("f_rel_chg",  32'(pat_chg), 32'd0);

      check("sb_drained", 32'(q_pat.size()), 32'd0);
      check("chg_total",  32'(n_chg), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
